spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

Synthesizable SPI responder (slave) that sits on the far end of the SPI bus driven by the SoC SPI master, or by the `spi_agent` in master mode. It oversamples `sclk`, `mosi` and `cs_n` on the system clock, shifts full-duplex frames of `DATA_W` bits MSB-first, and exposes a ready/valid byte interface to local logic. `miso` is driven through an output-enable pair so the top level can tri-state the pad, matching the bus's weak-pull-up wiring.

## Interface
Parameters:
- `DATA_W`, 8: frame width in bits (4..32).
- `CPOL`, 0: sclk idle level.
- `CPHA`, 0: 0 samples on the leading edge; 1 samples on the trailing edge.
- `FILL`, all ones: word shifted out on tx underrun.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  system clock; must be at least 4x the sclk frequency.
- `rst`  in  1  asynchronous active-high reset.
- `sclk_i`  in  1  raw SPI clock pad input.
- `mosi_i`  in  1  raw MOSI pad input.
- `cs_n_i`  in  1  raw chip select, active low.
- `miso_o`  out  1  MISO data value.
- `miso_oe`  out  1  1 = drive `miso_o` onto the pad; 0 = release (pull-up).
- `rx_data`  out  DATA_W  last received frame.
- `rx_valid`  out  1  `rx_data` holds an unconsumed frame.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `tx_data`  in  DATA_W  next frame to send.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  one-entry tx holding register is empty.
- `busy`  out  1  cs asserted (synchronized).
- `overrun`  out  1  sticky; cleared only by reset.
- `underrun`  out  1  one-cycle pulse when `FILL` is loaded.

## Operation
- Inputs pass through 2-flop synchronizers, followed by a 1-flop edge detector.
- The leading edge is the sclk transition away from `CPOL`. The sample edge is the leading edge if `CPHA`=0, otherwise the trailing edge. The shift edge is the other one.
- State machine:
  - IDLE: cs high. A cs fall moves to LOAD.
  - LOAD: one cycle. The tx shift register takes the holding register if it is full (which frees it), otherwise `FILL` with an `underrun` pulse. `miso_oe` goes to 1. If `CPHA`=0, `miso_o` takes the MSB now.
  - SHIFT: each sample edge shifts `mosi` into the rx shift register and increments the bit counter (0..DATA_W-1). Each shift edge presents the next tx bit.
    - `CPHA`=1: the first leading edge presents the MSB.
    - When the counter wraps from DATA_W-1, the frame is complete: rx is transferred and the next tx word is loaded exactly as in LOAD, with no sclk gap required.
  - Any cs rise, from any state, goes to IDLE. The partial frame is discarded, with no `rx_valid` and no rx_data change. The counter clears and `miso_oe` goes to 0. A tx word already loaded into the shift register is lost; the holding register is untouched.
- rx handshake:
  - `rx_valid` rises on frame completion and holds until `rx_valid && rx_ready`.
  - If a frame completes while `rx_valid` is still 1, `rx_data` is overwritten and `overrun` sets.
- tx handshake:
  - `tx_valid && tx_ready` writes the holding register, and `tx_ready` drops the next cycle.
  - If the write coincides with a load in the same cycle, the load takes the old content (or `FILL`) and the new word is stored.

## Timing
- Reset values: `miso_o`=1, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `busy`=0, `overrun`=0, `underrun`=0; state IDLE; counters 0.
- The pad-to-internal-edge latency is 3 `clk` cycles (2 sync + 1 detect).
- `miso_o` changes 4 clk after the shift sclk edge.
- `rx_valid` rises 4 clk after the last sample edge.
- `busy` follows cs with 3 clk latency.
- `miso_oe` rises 4 clk after the cs fall and falls 4 clk after the cs rise.
- Requirement: the sclk half-period must be at least 5 clk so that `miso` is stable before the master samples. Below 4x oversampling, behaviour is undefined.

## Structure
- Shared package `spi_pkg`: state enum (IDLE/LOAD/SHIFT), mode struct {cpol, cpha}, default `FILL` constant.
- Sub-module `spi_sync_edge`: N-stage synchronizer plus rise/fall detect, instantiated for sclk, mosi and cs_n.
- Pad tri-stating (`assign miso = miso_oe ? miso_o : 'z`) belongs to the top level, not this block.

## Test plan
- Mode 0, DATA_W=8: preload tx 0xA5, master sends 0x3C. Required: master reads 0xA5, `rx_data`=0x3C, one `rx_valid`, `underrun` never fires.
- Modes 1, 2 and 3, each with 0x81 in both directions: correct bit order; first MISO bit valid at the first sample edge.
- Two back-to-back frames with only 0x11 queued. Required: second word out = 0xFF, `underrun` pulses once, master rx = 0x11, 0xFF.
- Hold `rx_ready`=0 across two frames (0x01, 0x02). Required: `rx_data`=0x02, `overrun`=1 sticky, `rx_valid` stays 1.
- Raise cs after 5 bits, then run a full frame 0x55. Required: no `rx_valid` for the aborted frame, then `rx_data`=0x55, and `miso_oe`=0 between frames.
- Assert `rst` mid-frame. Required: all outputs return to their reset values asynchronously, and the next full frame after release works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder and its input conditioning.
package spi_pkg;

    localparam int unsigned MAX_DATA_W = 32;
    localparam int unsigned SYNC_STAGES = 2;

    // Word shifted out when the host has nothing queued.
    localparam logic [MAX_DATA_W-1:0] FILL_DEFAULT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pad input, with registered
// rise/fall pulses one cycle behind the synchronized level.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter bit          RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI responder: oversamples the SPI pads on clk, shifts full-duplex frames
// MSB-first and exposes ready/valid rx and tx word interfaces.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned        DATA_W = 8,
    parameter bit                 CPOL   = 1'b0,
    parameter bit                 CPHA   = 1'b0,
    parameter logic [DATA_W-1:0]  FILL   = FILL_DEFAULT[DATA_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              cs_n_i,
    output logic              miso_o,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              underrun
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam spi_mode_t         MODE     = '{cpol: CPOL, cpha: CPHA};

    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic cs_level,   cs_rise,   cs_fall;
    logic unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk_i),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (mosi_i),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (cs_n_i),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign unused_edges = sclk_level ^ mosi_rise ^ mosi_fall;

    // Leading edge moves sclk away from its idle level; CPHA picks which edge samples.
    logic lead_c, trail_c, sample_c, shift_c;
    assign lead_c   = MODE.cpol ? sclk_fall : sclk_rise;
    assign trail_c  = MODE.cpol ? sclk_rise : sclk_fall;
    assign sample_c = MODE.cpha ? trail_c : lead_c;
    assign shift_c  = MODE.cpha ? lead_c  : trail_c;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] rx_data_d;
    logic [DATA_W-1:0] tx_next;
    logic              miso_d, miso_oe_d, rx_valid_d, tx_ready_d;
    logic              busy_d, overrun_d, underrun_d;
    logic              do_load, do_present, complete;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        hold_d     = hold_q;
        rx_data_d  = rx_data;
        miso_d     = miso_o;
        miso_oe_d  = miso_oe;
        rx_valid_d = rx_valid;
        tx_ready_d = tx_ready;
        overrun_d  = overrun;
        underrun_d = 1'b0;
        busy_d     = ~cs_level;
        do_load    = 1'b0;
        do_present = 1'b0;
        complete   = 1'b0;
        tx_next    = tx_sr_q;

        if (cs_rise) begin
            // Deselect aborts whatever frame is in flight.
            state_d   = IDLE;
            cnt_d     = '0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = LOAD;
                        miso_oe_d = 1'b1;
                    end
                end
                LOAD: begin
                    do_load    = 1'b1;
                    do_present = !MODE.cpha;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
                SHIFT: begin
                    if (sample_c) begin
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_level};
                        if (cnt_q == LAST_BIT) begin
                            cnt_d      = '0;
                            complete   = 1'b1;
                            do_load    = 1'b1;
                            do_present = !MODE.cpha;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (shift_c && (MODE.cpha || cnt_q != '0)) begin
                        // CPHA=0 already presented the MSB at load time; skip the
                        // trailing edge that closes a frame.
                        do_present = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (rx_valid && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (complete) begin
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            if (rx_valid && !rx_ready) begin
                overrun_d = 1'b1;
            end
        end

        // Load takes the holding register content, or FILL when it is empty.
        if (do_load) begin
            if (tx_ready) begin
                tx_next    = FILL;
                underrun_d = 1'b1;
            end else begin
                tx_next    = hold_q;
                tx_ready_d = 1'b1;
            end
        end
        if (do_present) begin
            miso_d  = tx_next[DATA_W-1];
            tx_next = {tx_next[DATA_W-2:0], 1'b0};
        end
        tx_sr_d = tx_next;

        if (tx_valid && tx_ready) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rx_sr_q  <= '0;
            tx_sr_q  <= '0;
            hold_q   <= '0;
            rx_data  <= '0;
            miso_o   <= 1'b1;
            miso_oe  <= 1'b0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_sr_q  <= rx_sr_d;
            tx_sr_q  <= tx_sr_d;
            hold_q   <= hold_d;
            rx_data  <= rx_data_d;
            miso_o   <= miso_d;
            miso_oe  <= miso_oe_d;
            rx_valid <= rx_valid_d;
            tx_ready <= tx_ready_d;
            busy     <= busy_d;
            overrun  <= overrun_d;
            underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench: one responder per SPI mode, driven by a bit-banged master,
// with rx and master-read scoreboards.
module tb_spi_slave_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned H = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mosi;
    logic [W-1:0] tx_data;
    logic         sclk     [4];
    logic         cs_n     [4];
    logic         miso_o   [4];
    logic         miso_oe  [4];
    logic [W-1:0] rx_data  [4];
    logic         rx_valid [4];
    logic         rx_ready [4];
    logic         tx_valid [4];
    logic         tx_ready [4];
    logic         busy     [4];
    logic         overrun  [4];
    logic         underrun [4];

    int checks   = 0;
    int failures = 0;
    int hs_cnt [4];
    int un_cnt [4];
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_ctrl #(
            .DATA_W (W),
            .CPOL   (g >= 2),
            .CPHA   (g % 2 == 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .sclk_i   (sclk[g]),
            .mosi_i   (mosi),
            .cs_n_i   (cs_n[g]),
            .miso_o   (miso_o[g]),
            .miso_oe  (miso_oe[g]),
            .rx_data  (rx_data[g]),
            .rx_valid (rx_valid[g]),
            .rx_ready (rx_ready[g]),
            .tx_data  (tx_data),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .busy     (busy[g]),
            .overrun  (overrun[g]),
            .underrun (underrun[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs just before each rising edge: counts pulses and scores rx handshakes.
    task automatic monitor();
        logic [7:0] exp;
        for (int m = 0; m < 4; m++) begin
            if (underrun[m] === 1'b1) un_cnt[m]++;
            if (rx_valid[m] === 1'b1 && rx_ready[m] === 1'b1) begin
                hs_cnt[m]++;
                chk("rx_expected_pending", 32'(rx_q.size() > 0), 32'd1);
                if (rx_q.size() > 0) begin
                    exp = rx_q.pop_front();
                    chk("rx_data_at_handshake", 32'(rx_data[m]), 32'(exp));
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic pad_miso(input int m);
        return (miso_oe[m] === 1'b1) ? miso_o[m] : 1'b1;
    endfunction

    task automatic write_tx(input int m, input logic [7:0] d);
        int n;
        n = 0;
        while (tx_ready[m] !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        chk("tx_ready_before_write", 32'(tx_ready[m]), 32'd1);
        tx_data     = d;
        tx_valid[m] = 1'b1;
        tick(1);
        tx_valid[m] = 1'b0;
    endtask

    task automatic check_miso(input logic [7:0] r);
        logic [7:0] exp;
        chk("miso_expected_pending", 32'(tx_q.size() > 0), 32'd1);
        if (tx_q.size() > 0) begin
            exp = tx_q.pop_front();
            chk("master_read_word", 32'(r), 32'(exp));
        end
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        tick(8);
    endtask

    task automatic cs_high(input int m);
        cs_n[m] = 1'b1;
        tick(8);
    endtask

    task automatic xfer(input int m, input logic [7:0] w, input int nbits, output logic [7:0] r);
        logic cpol;
        logic cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        r = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = w[i];
                tick(H);
                r = {r[6:0], pad_miso(m)};
                sclk[m] = ~cpol;
                tick(H);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi = w[i];
                tick(H);
                r = {r[6:0], pad_miso(m)};
                sclk[m] = cpol;
                tick(H);
            end
        end
        tick(H);
    endtask

    initial begin
        logic [7:0] r;
        int u0;
        int h0;

        mosi    = 1'b1;
        tx_data = '0;
        for (int m = 0; m < 4; m++) begin
            sclk[m]     = (m >= 2);
            cs_n[m]     = 1'b1;
            rx_ready[m] = 1'b1;
            tx_valid[m] = 1'b0;
            hs_cnt[m]   = 0;
            un_cnt[m]   = 0;
        end

        rst = 1'b1;
        tick(3);
        chk("reset_miso_o",   32'(miso_o[0]),   32'd1);
        chk("reset_miso_oe",  32'(miso_oe[0]),  32'd0);
        chk("reset_rx_data",  32'(rx_data[0]),  32'd0);
        chk("reset_rx_valid", 32'(rx_valid[0]), 32'd0);
        chk("reset_tx_ready", 32'(tx_ready[0]), 32'd1);
        chk("reset_busy",     32'(busy[0]),     32'd0);
        chk("reset_overrun",  32'(overrun[0]),  32'd0);
        chk("reset_underrun", 32'(underrun[0]), 32'd0);
        rst = 1'b0;
        tick(4);

        // Mode 0 basic frame: slave sends 0xA5, master sends 0x3C.
        write_tx(0, 8'hA5);
        chk("hold_full_after_write", 32'(tx_ready[0]), 32'd0);
        tx_q.push_back(8'hA5);
        rx_q.push_back(8'h3C);
        u0 = un_cnt[0];
        h0 = hs_cnt[0];
        cs_low(0);
        chk("m0_busy",          32'(busy[0]),     32'd1);
        chk("m0_miso_oe",       32'(miso_oe[0]),  32'd1);
        chk("m0_load_frees",    32'(tx_ready[0]), 32'd1);
        write_tx(0, 8'h5A);
        xfer(0, 8'h3C, 8, r);
        check_miso(r);
        cs_high(0);
        chk("m0_miso_oe_off",   32'(miso_oe[0]),  32'd0);
        chk("m0_busy_off",      32'(busy[0]),     32'd0);
        chk("m0_one_rx_valid",  32'(hs_cnt[0] - h0), 32'd1);
        chk("m0_no_underrun",   32'(un_cnt[0] - u0), 32'd0);

        // Modes 1..3 with 0x81 in both directions.
        for (int m = 1; m < 4; m++) begin
            h0 = hs_cnt[m];
            write_tx(m, 8'h81);
            tx_q.push_back(8'h81);
            rx_q.push_back(8'h81);
            cs_low(m);
            xfer(m, 8'h81, 8, r);
            check_miso(r);
            cs_high(m);
            chk("mode_rx_frames", 32'(hs_cnt[m] - h0), 32'd1);
        end

        // Back-to-back frames with only 0x11 queued for the first word.
        write_tx(0, 8'h11);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'hFF);
        rx_q.push_back(8'hA1);
        rx_q.push_back(8'hB2);
        u0 = un_cnt[0];
        cs_low(0);
        chk("b2b_no_underrun_first", 32'(un_cnt[0] - u0), 32'd0);
        xfer(0, 8'hA1, 8, r);
        check_miso(r);
        chk("b2b_underrun_once", 32'(un_cnt[0] - u0), 32'd1);
        write_tx(0, 8'h77);
        xfer(0, 8'hB2, 8, r);
        check_miso(r);
        cs_high(0);
        chk("b2b_underrun_total", 32'(un_cnt[0] - u0), 32'd1);

        // Overrun: consumer stalls across two frames.
        rx_ready[0] = 1'b0;
        rx_q.push_back(8'h02);
        cs_low(0);
        xfer(0, 8'h01, 8, r);
        chk("ovr_first_valid",   32'(rx_valid[0]), 32'd1);
        chk("ovr_first_data",    32'(rx_data[0]),  32'h01);
        chk("ovr_not_yet",       32'(overrun[0]),  32'd0);
        xfer(0, 8'h02, 8, r);
        cs_high(0);
        chk("ovr_data",          32'(rx_data[0]),  32'h02);
        chk("ovr_valid_held",    32'(rx_valid[0]), 32'd1);
        chk("ovr_flag",          32'(overrun[0]),  32'd1);
        rx_ready[0] = 1'b1;
        tick(2);
        chk("ovr_valid_cleared", 32'(rx_valid[0]), 32'd0);
        chk("ovr_sticky",        32'(overrun[0]),  32'd1);

        // Abort after 5 bits, then a full frame 0x55.
        h0 = hs_cnt[0];
        cs_low(0);
        xfer(0, 8'hF0, 5, r);
        cs_high(0);
        chk("abort_miso_oe",     32'(miso_oe[0]),  32'd0);
        chk("abort_no_valid",    32'(rx_valid[0]), 32'd0);
        chk("abort_data_kept",   32'(rx_data[0]),  32'h02);
        chk("abort_no_frame",    32'(hs_cnt[0] - h0), 32'd0);
        rx_q.push_back(8'h55);
        cs_low(0);
        xfer(0, 8'h55, 8, r);
        cs_high(0);
        chk("after_abort_frame", 32'(hs_cnt[0] - h0), 32'd1);
        chk("after_abort_data",  32'(rx_data[0]),  32'h55);

        // Reset asserted mid-frame, checked before any clock edge.
        cs_low(0);
        xfer(0, 8'hCC, 3, r);
        rst = 1'b1;
        #1;
        chk("async_miso_o",   32'(miso_o[0]),   32'd1);
        chk("async_miso_oe",  32'(miso_oe[0]),  32'd0);
        chk("async_rx_data",  32'(rx_data[0]),  32'd0);
        chk("async_rx_valid", 32'(rx_valid[0]), 32'd0);
        chk("async_tx_ready", 32'(tx_ready[0]), 32'd1);
        chk("async_busy",     32'(busy[0]),     32'd0);
        chk("async_overrun",  32'(overrun[0]),  32'd0);
        chk("async_underrun", 32'(underrun[0]), 32'd0);
        cs_n[0] = 1'b1;
        sclk[0] = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);

        h0 = hs_cnt[0];
        write_tx(0, 8'h96);
        tx_q.push_back(8'h96);
        rx_q.push_back(8'h69);
        cs_low(0);
        write_tx(0, 8'h00);
        xfer(0, 8'h69, 8, r);
        check_miso(r);
        cs_high(0);
        chk("post_reset_frame",   32'(hs_cnt[0] - h0), 32'd1);
        chk("post_reset_overrun", 32'(overrun[0]),     32'd0);

        chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
        chk("tx_q_drained", 32'(tx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
